// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder/subtractor whose carry ripples through STAGES
// register stages, one CHUNK = WIDTH/STAGES-bit slice per stage. Accepts a new
// operand set every cycle. Flow control lets bubbles collapse toward the output.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake (A, B, Cin, Sub sampled on accept)
//   A, B                WIDTH-bit operands
//   Cin                 carry-in (borrow-in when Sub=1)
//   Sub                 0: A+B+Cin, 1: A-B-Cin
//   out_valid, out_ready result handshake
//   Sum, Cout, Ovf      result mod 2^WIDTH, MSB carry-out, signed overflow
//
// WIDTH must be divisible by STAGES, and STAGES must lie in 1..WIDTH.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  // Returns {carry into chunk MSB, carry out, chunk sum}.
  function automatic logic [CHUNK+1:0] add_chunk(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             c);
    logic [CHUNK:0] tot;
    logic           c_msb;
    tot   = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    c_msb = tot[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    return {c_msb, tot};
  endfunction

  // Per-stage state. a_q/b_q carry the operands forward; only the chunks above
  // the stage index still matter. s_q holds the finished low chunks.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              ovf_q;

  // Stage inputs (what each stage would load) and next-state values.
  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] c_src;
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [WIDTH-1:0]  s_d   [STAGES];
  logic [STAGES-1:0] c_d;
  logic              ovf_d;
  logic [STAGES-1:0] stage_ready;

  // A stage may load when it or any stage downstream is empty, or when the
  // output is being consumed. Written as an OR over the tail so there is no
  // combinational self-dependency in the ready vector.
  always_comb begin
    logic rdy;
    stage_ready = '0;
    for (int k = 0; k < STAGES; k++) begin
      rdy = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!v_q[j]) rdy = 1'b1;
      end
      stage_ready[k] = rdy;
    end
  end

  assign in_ready = stage_ready[0];

  // Stage sources: stage 0 takes the effective operands, stage k the registers
  // of stage k-1.
  always_comb begin
    v_src    = '0;
    c_src    = '0;
    v_src[0] = in_valid;
    c_src[0] = Cin ^ Sub;
    a_src[0] = A;
    b_src[0] = Sub ? ~B : B;
    s_src[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = v_q[k-1];
      c_src[k] = c_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
    end
  end

  // Chunk k is added in stage k; the top stage also resolves overflow.
  always_comb begin
    logic [CHUNK+1:0] res;
    c_d   = '0;
    ovf_d = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      res = add_chunk(a_src[k][k*CHUNK +: CHUNK], b_src[k][k*CHUNK +: CHUNK], c_src[k]);
      s_d[k] = s_src[k];
      s_d[k][k*CHUNK +: CHUNK] = res[CHUNK-1:0];
      c_d[k] = res[CHUNK];
      if (k == STAGES - 1) ovf_d = res[CHUNK+1] ^ res[CHUNK];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_ready[k]) begin
          v_q[k] <= v_src[k];
          c_q[k] <= c_d[k];
          a_q[k] <= a_src[k];
          b_q[k] <= b_src[k];
          s_q[k] <= s_d[k];
        end
      end
      if (stage_ready[STAGES-1]) ovf_q <= ovf_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign Sum       = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign Ovf       = ovf_q;

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined N-bit adder/subtractor with carry-in, carry-out and signed-overflow flags. Operands enter through a valid/ready handshake. The carry ripples through STAGES register stages, each handling one WIDTH/STAGES-bit chunk, so a new operation can be accepted every cycle. It is the multi-bit, sequential successor of the single-bit full adder and is the arithmetic building block for the upcoming datapath exercises.

## Interface
- WIDTH, 16, operand and result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages; each stage adds one CHUNK = WIDTH/STAGES-bit slice; range 1..WIDTH.
- One clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set on A/B/Cin/Sub is valid.
- in_ready  output  1  pipeline can accept an operand set this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in (borrow-in when Sub=1).
- Sub  input  1  0: A+B+Cin; 1: A-B-Cin.
- out_valid  output  1  Sum/Cout/Ovf hold a result.
- out_ready  input  1  downstream consumes the result this cycle.
- Sum  output  WIDTH  result modulo 2^WIDTH.
- Cout  output  1  carry out of the MSB (in Sub mode: 1 = no borrow).
- Ovf  output  1  two's-complement signed overflow.

## Operation
- Effective operands: B' = Sub ? ~B : B; c0 = Cin ^ Sub. Result = A + B' + c0, width WIDTH+1 (Cout = bit WIDTH).
- Stage k (0..STAGES-1) computes chunk k: {c_out_k, S_k} = A_k + B'_k + c_in_k, where c_in_0 = c0 and c_in_k = the registered carry from stage k-1.
- Skew registers: stage k holds the finished Sum chunks 0..k, its carry, the untouched A/B' chunks k+1..STAGES-1, and the MSB carry-in (for Ovf) once that chunk is computed.
- Ovf = carry into MSB XOR carry out of MSB, resolved in the stage holding the top chunk.
- Per-stage valid bit v[k]. Define stage_ready[STAGES] = out_ready and stage_ready[k] = !v[k] || stage_ready[k+1]. This gives bubble-collapsing flow control.
- in_ready = stage_ready[0] (combinational from out_ready and the valid bits).
- Stage k loads from stage k-1 (or from the inputs for k=0) when stage_ready[k]. Its valid becomes v[k-1] (or in_valid && in_ready for k=0).
- out_valid = v[STAGES-1]. Sum/Cout/Ovf come directly from the last stage's registers.
- A stage that does not advance holds its data and valid unchanged.
- STAGES=1 degenerates to a single registered adder with the same handshake.
- WIDTH=1, STAGES=1 behaves as a registered full adder: Sum=A^B^Cin, Cout=maj(A,B,Cin).

## Timing
- Reset (rst_n low, asynchronous) clears all v[k], Sum, Cout and Ovf to 0. It does so immediately, without waiting for clk. After reset, in_ready=1 and out_valid=0.
- Reset mid-operation discards every in-flight result. No stale result may appear after rst_n rises.
- Latency: an operand accepted at edge t drives out_valid=1 after edge t+STAGES-1. With STAGES=4 the result is visible in the 4th cycle after acceptance.
- Throughput: 1 result per cycle while out_ready=1. Results leave in acceptance order.
- Backpressure: while out_valid && !out_ready, Sum/Cout/Ovf stay stable. Upstream bubbles keep collapsing. in_ready falls once all STAGES stages are full.
- Capacity: at most STAGES results in flight. No operand is dropped or duplicated.
- Simultaneous accept and output when the pipe is full: if out_ready=1, in_ready=1 in the same cycle and both transfers occur on that edge.
- A/B/Cin/Sub are only sampled on an accepting edge. Values while in_valid=0 or in_ready=0 are ignored.

## Test plan
- Reset: hold rst_n=0 mid-clock -> out_valid=0, Sum=0, Cout=0, Ovf=0, in_ready=1. Check immediately, with no clock edge.
- Carry chain (16/4): A=16'hFFFF, B=16'h0001, Cin=0, Sub=0 -> 4 cycles later Sum=16'h0000, Cout=1, Ovf=0.
- Overflow/subtract: A=16'h7FFF, B=16'h0001 -> Sum=16'h8000, Cout=0, Ovf=1. Then A=16'h0005, B=16'h0007, Sub=1, Cin=0 -> Sum=16'hFFFE, Cout=0, Ovf=0.
- WIDTH=1, STAGES=1 instance: all 8 {A,B,Cin} combinations -> full-adder truth table, each result 1 cycle after acceptance.
- Stream with backpressure: issue 10 random ops back-to-back and hold out_ready=0 for cycles 3-8. Expect in_ready=0 after 4 ops are held, outputs stable while stalled, then all 10 results in order against a reference model.
- Reset mid-stream: pulse rst_n low with 3 ops in flight -> out_valid drops at once, and no result from those ops appears after release.
